rip_mem_align: RTL and testbench
================================

Name: rip_mem_align

Overview:
- Load/store alignment unit between the core's memory stage and a bus-wide data memory port.
- Accepts one byte, half, word or double access per request at any byte address.
- Generates byte strobes and lane-shifted write data.
- Splits accesses that cross a bus-word boundary into two beats, then reassembles and sign/zero-extends load data to XLEN.

Parameters:
- XLEN, 32, register width; legal values 32 or 64.
- BUS_WIDTH, XLEN, memory data width in bits; power of two, at least XLEN.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  access request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- req_unsigned  in  1  zero-extend the load result
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  XLEN  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse; the core always accepts it
- rsp_rdata  out  XLEN  extended load data; 0 for stores
- rsp_err  out  1  illegal size, valid with rsp_valid
- mem_valid  out  1  beat request
- mem_ready  in  1  memory accepts the beat
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_WIDTH  bus-aligned address (low log2(BUS_WIDTH/8) bits zero)
- mem_wstrb  out  BUS_WIDTH/8  byte enables
- mem_wdata  out  BUS_WIDTH  lane-shifted write data
- mem_rvalid  in  1  read data valid; in order, one outstanding read
- mem_rdata  in  BUS_WIDTH  read data

Behaviour:
- Reset: state IDLE; req_ready=1; mem_valid=0; rsp_valid=0; rsp_err=0; mem_wstrb=0; mem_addr=0; mem_wdata=0; rsp_rdata=0; beat buffers cleared.
- Reset asserted mid-access drops the access: no further beats and no response.
- Definitions:
  - BB = BUS_WIDTH/8.
  - off = req_addr mod BB.
  - nbytes = 1 << req_size.
  - mask = (2^nbytes − 1) << off, computed 2*BB bits wide.
  - Access is split when off + nbytes > BB.
- Request acceptance:
  - req_ready=1 only in IDLE; handshake is req_valid && req_ready.
  - Request fields are registered on acceptance; inputs are ignored afterwards.
- Illegal size: req_size=3 with XLEN=32 is illegal. It issues no beat, and rsp_valid with rsp_err=1 is asserted the cycle after acceptance.
- States:
  - IDLE -> BEAT0 on accept.
  - BEAT0: mem_valid=1, mem_addr = addr & ~(BB−1), mem_wstrb = mask[BB−1:0], mem_wdata = low BUS_WIDTH bits of (req_wdata << 8*off). Held stable until mem_ready=1.
    - On accept: store and not split -> RESP; store and split -> BEAT1; load -> RD0.
  - RD0: capture mem_rdata on mem_rvalid into buf0. Then -> BEAT1 if split, else RESP.
  - BEAT1: mem_addr = beat-0 address + BB, wrapping modulo 2^ADDR_WIDTH. mem_wstrb = mask[2BB−1:BB]. mem_wdata = high half of the shifted data.
    - On accept: load -> RD1; store -> RESP.
  - RD1: capture buf1 on mem_rvalid, then -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Load result: take ({buf1, buf0} >> 8*off), keep its low nbytes bytes, then extend to XLEN.
  - Sign-extend unless req_unsigned=1.
  - req_unsigned is ignored when nbytes = XLEN/8.
- Latency, aligned store with mem_ready always 1: accept at cycle T, beat at T+1, rsp_valid at T+2.
  - Aligned load adds read latency: rsp_valid is one cycle after mem_rvalid.
  - A split access adds one beat; a split load also waits for its second mem_rvalid.
- Ignored inputs: mem_rvalid is ignored outside RD0/RD1; mem_ready is ignored when mem_valid=0.
- No back-to-back acceptance: the earliest next accept is the cycle after rsp_valid.

Decomposition:
- Shared package rip_mem_pkg:
  - size enum mem_size_e {MEM_B, MEM_H, MEM_W, MEM_D}.
  - B/H/W/D width constants, taken from the existing constant package.
  - Function size_bytes().
- One combinational sub-module, rip_lane_shift: mask, strobe and write-data shift, plus the read extract/extend. It is reused by the instruction-fetch path.

Test Plan:
- XLEN=32: store W 0xDEADBEEF at 0x100 -> one beat, mem_addr=0x100, wstrb=4'b1111, wdata=0xDEADBEEF, rsp_valid at T+2.
- Load B from 0x103, mem_rdata=0x80112233 -> one beat; rsp_rdata=0xFFFFFF80; with req_unsigned=1, 0x00000080.
- Store H 0xABCD at 0x203 ->
  - beat0: addr=0x200, wstrb=4'b1000, wdata[31:24]=0xCD.
  - beat1: addr=0x204, wstrb=4'b0001, wdata[7:0]=0xAB.
- Split load W at 0x102, rdata0=0x44332211 and rdata1=0x88776655 -> rsp_rdata=0x66554433. Repeat with 3-cycle mem_ready stalls: beat signals stay stable and the result is unchanged.
- XLEN=64: load D at 0x0FFF_FFFC -> split, beat1 addr=0x1000_0000. Same access at 0xFFFF_FFFC -> beat1 addr wraps to 0x0000_0000.
- XLEN=32 size D -> no mem_valid, rsp_err=1. Separately, assert rstn low during RD0 -> no rsp_valid; outputs return to reset values; req_ready=1.

Source files
------------

// File: rtl/rip_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rip_mem_pkg
// Purpose  : Shared access-size encoding, width constants and helpers for the
//            load/store alignment path and its lane-shift datapath.
// Revision : 1.0 - initial release
// ============================================================================
package rip_mem_pkg;

  // Access size encoding as it arrives from the core.
  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  // Operand widths in bits for each access size.
  localparam int unsigned C_WIDTH_B = 8;
  localparam int unsigned C_WIDTH_H = 16;
  localparam int unsigned C_WIDTH_W = 32;
  localparam int unsigned C_WIDTH_D = 64;

  // Alignment sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_RD0   = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_RD1   = 3'd4,
    ST_RESP  = 3'd5
  } align_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input mem_size_e size);
    logic [3:0] nbytes;
    case (size)
      MEM_B:   nbytes = 4'(C_WIDTH_B / 8);
      MEM_H:   nbytes = 4'(C_WIDTH_H / 8);
      MEM_W:   nbytes = 4'(C_WIDTH_W / 8);
      default: nbytes = 4'(C_WIDTH_D / 8);
    endcase
    return nbytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rip_lane_shift.sv
`default_nettype none
// ============================================================================
// Module   : rip_lane_shift
// Purpose  : Combinational lane logic: byte mask, split detect, write-data
//            lane shift and read-data extract with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module rip_lane_shift
  import rip_mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = XLEN,
  localparam int BB       = BUS_WIDTH / 8,
  localparam int OFFW     = $clog2(BB)
) (
  input  logic [OFFW-1:0]      i_off,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [BUS_WIDTH-1:0] i_buf0,
  input  logic [BUS_WIDTH-1:0] i_buf1,
  output logic [2*BB-1:0]      o_mask,
  output logic                 o_split,
  output logic [BUS_WIDTH-1:0] o_wdata_lo,
  output logic [BUS_WIDTH-1:0] o_wdata_hi,
  output logic [XLEN-1:0]      o_rdata
);

  logic [3:0]             w_nbytes;
  logic [2*BB-1:0]        w_base;
  logic [2*BUS_WIDTH-1:0] w_wide;
  logic [XLEN-1:0]        w_rd_raw;
  logic                   w_sign;
  logic                   w_fill;

  assign w_nbytes = size_bytes(mem_size_e'(i_size));

  // Unshifted byte mask: the low nbytes bits set across a two-word window.
  always_comb begin
    w_base = '0;
    for (int i = 0; i < 2 * BB; i++) begin
      w_base[i] = (i < int'(w_nbytes));
    end
  end

  assign o_mask  = w_base << i_off;
  assign o_split = (int'(i_off) + int'(w_nbytes)) > BB;

  // Store data moves up by the byte offset; the overflow lands in beat 1.
  assign w_wide     = {{(2*BUS_WIDTH-XLEN){1'b0}}, i_wdata} << {i_off, 3'b000};
  assign o_wdata_lo = w_wide[BUS_WIDTH-1:0];
  assign o_wdata_hi = w_wide[2*BUS_WIDTH-1:BUS_WIDTH];

  // Load data: both beats concatenated and pulled down to bit 0.
  assign w_rd_raw = XLEN'({i_buf1, i_buf0} >> {i_off, 3'b000});

  // Sign bit is the top bit of the accessed operand.
  always_comb begin
    case (mem_size_e'(i_size))
      MEM_B:   w_sign = w_rd_raw[7];
      MEM_H:   w_sign = w_rd_raw[15];
      MEM_W:   w_sign = w_rd_raw[31];
      default: w_sign = w_rd_raw[XLEN-1];
    endcase
  end

  assign w_fill = w_sign & ~i_unsigned;

  // Bytes inside the operand pass through; bytes above it take the fill.
  // A full-width operand has no fill bytes, so i_unsigned is moot there.
  for (genvar gb = 0; gb < XLEN / 8; gb++) begin : g_byte
    assign o_rdata[8*gb +: 8] = (gb < int'(w_nbytes)) ? w_rd_raw[8*gb +: 8] : {8{w_fill}};
  end

endmodule
`default_nettype wire

// File: rtl/rip_mem_align.sv
`default_nettype none
// ============================================================================
// Module   : rip_mem_align
// Purpose  : Load/store alignment unit. Turns a byte/half/word/double access
//            at any address into one or two bus-aligned beats and returns
//            extended load data to the core.
// Revision : 1.0 - initial release
// ============================================================================
module rip_mem_align
  import rip_mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BUS_WIDTH  = XLEN,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    rsp_valid,
  output logic [XLEN-1:0]         rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BUS_WIDTH/8-1:0]  mem_wstrb,
  output logic [BUS_WIDTH-1:0]    mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [BUS_WIDTH-1:0]    mem_rdata
);

  localparam int BB   = BUS_WIDTH / 8;
  localparam int OFFW = $clog2(BB);
  localparam logic [ADDR_WIDTH-1:0] C_OFF_MASK = ADDR_WIDTH'(BB - 1);
  localparam logic [ADDR_WIDTH-1:0] C_BB_ADDR  = ADDR_WIDTH'(BB);

  align_state_e state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BB-1:0]         mem_wstrb_q, mem_wstrb_d;
  logic [BUS_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  we_q, we_d;
  mem_size_e             size_q, size_d;
  logic                  is_unsigned_q, is_unsigned_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]  buf0_q, buf0_d;
  logic [BUS_WIDTH-1:0]  buf1_q, buf1_d;

  logic                  w_idle;
  logic                  w_illegal;
  logic [OFFW-1:0]       w_ls_off;
  logic [1:0]            w_ls_size;
  logic                  w_ls_unsigned;
  logic [XLEN-1:0]       w_ls_wdata;
  logic [BUS_WIDTH-1:0]  w_ls_buf0;
  logic [BUS_WIDTH-1:0]  w_ls_buf1;
  logic [2*BB-1:0]       w_mask;
  logic                  w_split;
  logic [BUS_WIDTH-1:0]  w_wdata_lo;
  logic [BUS_WIDTH-1:0]  w_wdata_hi;
  logic [XLEN-1:0]       w_rdata;
  logic [ADDR_WIDTH-1:0] w_beat1_addr;

  assign w_idle    = (state_q == ST_IDLE);
  assign w_illegal = (XLEN == 32) && (req_size == 2'd3);

  // In IDLE the lane logic sees the live request so beat 0 can be registered
  // on the accept edge; afterwards it works from the captured fields. Read
  // buffers are bypassed with mem_rdata on the capture cycle so the result
  // is registered together with the final beat.
  assign w_ls_off      = w_idle ? req_addr[OFFW-1:0] : addr_q[OFFW-1:0];
  assign w_ls_size     = w_idle ? req_size : size_q;
  assign w_ls_unsigned = w_idle ? req_unsigned : is_unsigned_q;
  assign w_ls_wdata    = w_idle ? req_wdata : wdata_q;
  assign w_ls_buf0     = (state_q == ST_RD0) ? mem_rdata : buf0_q;
  assign w_ls_buf1     = (state_q == ST_RD1) ? mem_rdata : buf1_q;
  assign w_beat1_addr  = (addr_q & ~C_OFF_MASK) + C_BB_ADDR;

  rip_lane_shift #(
    .XLEN      (XLEN),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_lane_shift (
    .i_off      (w_ls_off),
    .i_size     (w_ls_size),
    .i_unsigned (w_ls_unsigned),
    .i_wdata    (w_ls_wdata),
    .i_buf0     (w_ls_buf0),
    .i_buf1     (w_ls_buf1),
    .o_mask     (w_mask),
    .o_split    (w_split),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_rdata    (w_rdata)
  );

  // Next-state and next-output decode; every output leaves a flop.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    we_d          = we_q;
    size_d        = size_q;
    is_unsigned_d = is_unsigned_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d          = req_we;
          size_d        = mem_size_e'(req_size);
          is_unsigned_d = req_unsigned;
          addr_d        = req_addr;
          wdata_d       = req_wdata;
          buf0_d        = '0;
          buf1_d        = '0;
          req_ready_d   = 1'b0;
          if (w_illegal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_BEAT0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr & ~C_OFF_MASK;
            mem_wstrb_d = w_mask[BB-1:0];
            mem_wdata_d = w_wdata_lo;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          if (we_q && w_split) begin
            state_d     = ST_BEAT1;
            mem_addr_d  = w_beat1_addr;
            mem_wstrb_d = w_mask[2*BB-1:BB];
            mem_wdata_d = w_wdata_hi;
          end else begin
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wstrb_d = '0;
            mem_wdata_d = '0;
            if (we_q) begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = '0;
            end else begin
              state_d = ST_RD0;
            end
          end
        end
      end
      ST_RD0: begin
        if (mem_rvalid) begin
          buf0_d = mem_rdata;
          if (w_split) begin
            state_d     = ST_BEAT1;
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = w_beat1_addr;
            mem_wstrb_d = w_mask[2*BB-1:BB];
            mem_wdata_d = w_wdata_hi;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = w_rdata;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wstrb_d = '0;
          mem_wdata_d = '0;
          if (we_q) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_RD1;
          end
        end
      end
      ST_RD1: begin
        if (mem_rvalid) begin
          buf1_d      = mem_rdata;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = w_rdata;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State, captured request, beat buffers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= MEM_B;
      is_unsigned_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      we_q          <= we_d;
      size_q        <= size_d;
      is_unsigned_q <= is_unsigned_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rip_mem_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_rip_mem_align
// Purpose  : Directed self-checking bench for rip_mem_align, one 32-bit and
//            one 64-bit instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rip_mem_align;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // 64-bit instance
  logic        d64_req_valid, d64_req_we, d64_req_unsigned;
  logic [1:0]  d64_req_size;
  logic [31:0] d64_req_addr;
  logic [63:0] d64_req_wdata;
  logic        d64_req_ready, d64_rsp_valid, d64_rsp_err;
  logic [63:0] d64_rsp_rdata;
  logic        d64_mem_valid, d64_mem_ready, d64_mem_we, d64_mem_rvalid;
  logic [31:0] d64_mem_addr;
  logic [63:0] d64_mem_wdata, d64_mem_rdata;
  logic [7:0]  d64_mem_wstrb;

  int n_cmp = 0;
  int n_mis = 0;

  rip_mem_align #(.XLEN(32), .BUS_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  rip_mem_align #(.XLEN(64), .BUS_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rstn(rstn),
    .req_valid(d64_req_valid), .req_ready(d64_req_ready), .req_we(d64_req_we),
    .req_size(d64_req_size), .req_unsigned(d64_req_unsigned), .req_addr(d64_req_addr),
    .req_wdata(d64_req_wdata), .rsp_valid(d64_rsp_valid), .rsp_rdata(d64_rsp_rdata),
    .rsp_err(d64_rsp_err), .mem_valid(d64_mem_valid), .mem_ready(d64_mem_ready),
    .mem_we(d64_mem_we), .mem_addr(d64_mem_addr), .mem_wstrb(d64_mem_wstrb),
    .mem_wdata(d64_mem_wdata), .mem_rvalid(d64_mem_rvalid), .mem_rdata(d64_mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request on the 32-bit unit; returns at the negedge after accept.
  task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid    = 1'b0;
    req_we       = ~we;
    req_addr     = 32'h5555_5555;
    req_wdata    = 32'h5555_5555;
  endtask

  // Single-beat load on the 32-bit unit; memory answers one cycle after the beat.
  task automatic load32(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata);
    issue32(1'b0, size, uns, addr, 32'h0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
    @(negedge clk);
  endtask

  // Split double load on the 64-bit unit with fixed read data.
  task automatic load64_split(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    @(negedge clk);
    d64_req_valid    = 1'b1;
    d64_req_we       = 1'b0;
    d64_req_size     = 2'd3;
    d64_req_unsigned = 1'b0;
    d64_req_addr     = addr;
    @(negedge clk);
    d64_req_valid    = 1'b0;
    check_eq({tag, "_b0_valid"}, d64_mem_valid, 1);
    check_eq({tag, "_b0_addr"}, d64_mem_addr, exp_a0);
    check_eq({tag, "_b0_wstrb"}, d64_mem_wstrb, 8'hF0);
    @(negedge clk);
    d64_mem_rvalid = 1'b1;
    d64_mem_rdata  = 64'h8877_6655_4433_2211;
    @(negedge clk);
    d64_mem_rvalid = 1'b0;
    check_eq({tag, "_b1_valid"}, d64_mem_valid, 1);
    check_eq({tag, "_b1_addr"}, d64_mem_addr, exp_a1);
    check_eq({tag, "_b1_wstrb"}, d64_mem_wstrb, 8'h0F);
    @(negedge clk);
    d64_mem_rvalid = 1'b1;
    d64_mem_rdata  = 64'h00FF_EEDD_CCBB_AA99;
    @(negedge clk);
    d64_mem_rvalid = 1'b0;
    check_eq({tag, "_rsp_valid"}, d64_rsp_valid, 1);
    check_eq({tag, "_rdata"}, d64_rsp_rdata, 64'hCCBB_AA99_8877_6655);
    @(negedge clk);
    check_eq({tag, "_rsp_drop"}, d64_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_rsp;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 1; mem_rvalid = 0; mem_rdata = 0;
    d64_req_valid = 0; d64_req_we = 0; d64_req_size = 0; d64_req_unsigned = 0;
    d64_req_addr = 0; d64_req_wdata = 0;
    d64_mem_ready = 1; d64_mem_rvalid = 0; d64_mem_rdata = 0;

    // Reset values
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_mem_wstrb", mem_wstrb, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);

    // Aligned word store: beat at T+1, response at T+2
    issue32(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    check_eq("stw_busy", req_ready, 0);
    check_eq("stw_valid", mem_valid, 1);
    check_eq("stw_we", mem_we, 1);
    check_eq("stw_addr", mem_addr, 32'h100);
    check_eq("stw_wstrb", mem_wstrb, 4'b1111);
    check_eq("stw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("stw_no_rsp_yet", rsp_valid, 0);
    @(negedge clk);
    check_eq("stw_rsp_valid", rsp_valid, 1);
    check_eq("stw_rsp_err", rsp_err, 0);
    check_eq("stw_rsp_rdata", rsp_rdata, 0);
    check_eq("stw_beat_done", mem_valid, 0);
    @(negedge clk);
    check_eq("stw_rsp_pulse", rsp_valid, 0);
    check_eq("stw_ready_back", req_ready, 1);

    // Byte loads at the top lane, signed and unsigned
    load32("ldb_s", 2'd0, 1'b0, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    load32("ldb_u", 2'd0, 1'b1, 32'h103, 32'h8011_2233, 32'h0000_0080);
    load32("ldh_s", 2'd1, 1'b0, 32'h102, 32'h9234_5678, 32'hFFFF_9234);
    load32("ldw_u", 2'd2, 1'b1, 32'h100, 32'h8765_4321, 32'h8765_4321);

    // Split half store across the word boundary
    issue32(1'b1, 2'd1, 1'b0, 32'h203, 32'h0000_ABCD);
    check_eq("sth_b0_addr", mem_addr, 32'h200);
    check_eq("sth_b0_wstrb", mem_wstrb, 4'b1000);
    check_eq("sth_b0_wdata", mem_wdata[31:24], 8'hCD);
    @(negedge clk);
    check_eq("sth_b1_valid", mem_valid, 1);
    check_eq("sth_b1_addr", mem_addr, 32'h204);
    check_eq("sth_b1_wstrb", mem_wstrb, 4'b0001);
    check_eq("sth_b1_wdata", mem_wdata[7:0], 8'hAB);
    @(negedge clk);
    check_eq("sth_rsp_valid", rsp_valid, 1);
    @(negedge clk);

    // Split word load, no stalls
    issue32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    check_eq("ldsp_b0_addr", mem_addr, 32'h100);
    check_eq("ldsp_b0_wstrb", mem_wstrb, 4'b1100);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("ldsp_b1_valid", mem_valid, 1);
    check_eq("ldsp_b1_addr", mem_addr, 32'h104);
    check_eq("ldsp_b1_wstrb", mem_wstrb, 4'b0011);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("ldsp_rsp_valid", rsp_valid, 1);
    check_eq("ldsp_rdata", rsp_rdata, 32'h6655_4433);
    @(negedge clk);

    // Same split load with three-cycle mem_ready stalls on each beat
    mem_ready = 1'b0;
    issue32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_b0_valid", mem_valid, 1);
      check_eq("stall_b0_addr", mem_addr, 32'h100);
      check_eq("stall_b0_wstrb", mem_wstrb, 4'b1100);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_b1_valid", mem_valid, 1);
      check_eq("stall_b1_addr", mem_addr, 32'h104);
      check_eq("stall_b1_wstrb", mem_wstrb, 4'b0011);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("stall_rsp_valid", rsp_valid, 1);
    check_eq("stall_rdata", rsp_rdata, 32'h6655_4433);
    @(negedge clk);

    // Illegal double access on the 32-bit unit
    issue32(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    check_eq("ill_no_beat", mem_valid, 0);
    check_eq("ill_rsp_valid", rsp_valid, 1);
    check_eq("ill_rsp_err", rsp_err, 1);
    @(negedge clk);
    check_eq("ill_rsp_drop", rsp_valid, 0);
    check_eq("ill_err_drop", rsp_err, 0);
    check_eq("ill_ready_back", req_ready, 1);

    // 64-bit split double loads, including address wrap on beat 1
    load64_split("d64", 32'h0FFF_FFFC, 32'h0FFF_FFF8, 32'h1000_0000);
    load64_split("d64wrap", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0000);

    // Reset during RD0 drops the access
    issue32(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    check_eq("rrd_beat", mem_valid, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("rrd_ready", req_ready, 1);
    check_eq("rrd_mem_valid", mem_valid, 0);
    check_eq("rrd_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    saw_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      saw_rsp = saw_rsp | rsp_valid | mem_valid;
    end
    mem_rvalid = 1'b0;
    check_eq("rrd_no_activity", saw_rsp, 0);
    @(negedge clk);
    check_eq("rrd_ready_after", req_ready, 1);
    check_eq("rrd_rdata_after", rsp_rdata, 0);
    check_eq("rrd_addr_after", mem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
